// File: rtl/addr_reader.sv
// rtl/addr_reader.sv - buffer readout sequencer: one read per beat, valid/ready output handshake
//
// Reads `length` words (latched from wr_cnt_i on start_i) from a synchronous
// buffer with one-cycle read latency and presents them one at a time on a
// valid/ready output. Each beat walks ISSUE -> CAPTURE -> HOLD, so a beat
// costs three cycles when ready_i is held high.
//
// Parameters:
//   CNT_WIDTH  - address/count width
//   DATA_WIDTH - buffer word width
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start_i            - one-cycle request to begin readout (ignored while busy)
//   wr_cnt_i           - number of entries to read
//   rd_en_o, rd_addr_o - buffer read strobe and address
//   rd_data_i          - buffer data, valid one cycle after rd_en_o
//   data_o, valid_o    - read-out word and its valid
//   ready_i            - downstream accepts data_o
//   busy_o             - readout in progress
//   done_o             - one-cycle end-of-readout pulse (clears the write counter)
//   last_o             - valid_o on the final beat; present only with
//                        macro ADDR_READER_LAST_EN defined
module addr_reader #(
    parameter int CNT_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  wr_cnt_i,
    output logic                  rd_en_o,
    output logic [CNT_WIDTH-1:0]  rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o
`ifdef ADDR_READER_LAST_EN
    ,
    output logic                  last_o
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            state;
    logic [CNT_WIDTH-1:0]  addr;
    logic [CNT_WIDTH-1:0]  len;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  is_last;

    // len is never 0 outside IDLE/DONE, so len-1 cannot underflow where it matters.
    assign is_last = (addr == (len - CNT_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= '0;
            len    <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len   <= wr_cnt_i;
                        addr  <= '0;
                        state <= (wr_cnt_i == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    data_q <= rd_data_i;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (ready_i) begin
                        if (is_last) begin
                            state <= DONE;
                        end else begin
                            addr  <= addr + CNT_ONE;
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status strobes are masked by rst so they read 0 while reset is held,
    // not only after the reset edge has been taken.
    assign rd_en_o   = (state == ISSUE) && !rst;
    assign valid_o   = (state == HOLD)  && !rst;
    assign busy_o    = (state != IDLE)  && !rst;
    assign done_o    = (state == DONE)  && !rst;
    assign rd_addr_o = addr;
    assign data_o    = data_q;

`ifdef ADDR_READER_LAST_EN
    assign last_o = valid_o && is_last;
`endif

endmodule

// File: tb/tb_addr_reader.sv
// tb/tb_addr_reader.sv - self-checking bench for addr_reader with buffer model and beat scoreboard
module tb_addr_reader;

    localparam int CW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [CW-1:0] wr_cnt_i;
    logic          rd_en_o;
    logic [CW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          busy_o;
    logic          done_o;
`ifdef ADDR_READER_LAST_EN
    logic          last_o;
`endif

    addr_reader #(.CNT_WIDTH(CW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .wr_cnt_i  (wr_cnt_i),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o),
        .done_o    (done_o)
`ifdef ADDR_READER_LAST_EN
        ,
        .last_o    (last_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {8'hC3, b, ~b, b ^ 8'h5A};
    endfunction

    // Buffer model: one-cycle read latency, garbage when not being read.
    always @(posedge clk) begin
        if (rd_en_o) rd_data_i <= word(int'(rd_addr_o));
        else         rd_data_i <= 32'hDEAD_BEEF;
    end

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb[$];

    int cyc = 0;
    int run_len, run_beat, run_rd, run_done, run_busy;
    int start_cyc, last_acc_cyc;
    logic prev_hold = 1'b0;
    logic [DW-1:0] prev_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample one cycle at the falling edge, then advance past the next rising edge.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_data", data_o, prev_data);
            end
            if (rd_en_o) begin
                chk("rd_addr", rd_addr_o, run_rd);
                run_rd++;
            end
            if (busy_o) run_busy++;
`ifdef ADDR_READER_LAST_EN
            chk("last_o", last_o, valid_o && (run_beat == run_len - 1));
`endif
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", data_o, e);
                end
                run_beat++;
                last_acc_cyc = cyc;
            end
            if (done_o) begin
                run_done++;
                chk("done_busy", busy_o, 1);
                if (run_len > 0) chk("done_after_accept", cyc - last_acc_cyc, 1);
                else             chk("done_zero_len", cyc - start_cyc, 1);
            end
            prev_hold = valid_o && !ready_i;
            prev_data = data_o;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        wr_cnt_i  = CW'(n);
        start_i   = 1'b1;
        run_len   = n;
        run_beat  = 0;
        run_rd    = 0;
        run_done  = 0;
        run_busy  = 0;
        start_cyc = cyc;
        for (int i = 0; i < n; i++) sb.push_back(word(i));
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && run_done == 0; i++) tick();
        chk("done_timeout", run_done != 0, 1);
    endtask

    task automatic finish_run(input int n, input int exp_busy);
        repeat (4) tick();
        chk("rd_count", run_rd, n);
        chk("beat_count", run_beat, n);
        chk("done_count", run_done, 1);
        chk("sb_empty", sb.size(), 0);
        chk("busy_cycles", run_busy, exp_busy);
        chk("idle_busy", busy_o, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start_i  = 1'b0;
        wr_cnt_i = '0;
        ready_i  = 1'b1;
        run_len = 0; run_beat = 0; run_rd = 0; run_done = 0; run_busy = 0;
        start_cyc = 0; last_acc_cyc = 0;
        repeat (3) tick();
        chk("rst_rd_en", rd_en_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_addr", rd_addr_o, 0);
        rst = 1'b0;
        tick();

        // Four beats, ready held high: 3 cycles per beat plus DONE.
        do_start(4);
        wait_done(100);
        finish_run(4, 13);

        // Zero length: straight to DONE, no reads.
        do_start(0);
        wait_done(10);
        finish_run(0, 1);

        // Stall beat 1 for 5 cycles while it is valid.
        do_start(3);
        for (int i = 0; i < 50 && !(run_beat == 1 && valid_o); i++) tick();
        chk("stall_reach", (run_beat == 1) && valid_o, 1);
        ready_i = 1'b0;
        repeat (5) tick();
        ready_i = 1'b1;
        wait_done(100);
        finish_run(3, 15);

        // Length change and second start mid-readout are ignored.
        do_start(5);
        repeat (4) tick();
        wr_cnt_i = 8'd2;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        wait_done(100);
        finish_run(5, 16);

        // Reset while holding beat 2 of 6 aborts with no done.
        do_start(6);
        ready_i = 1'b0;
        for (int i = 0; i < 50 && !(run_beat == 1 && valid_o); i++) begin
            ready_i = (run_beat == 0) ? 1'b1 : 1'b0;
            tick();
        end
        ready_i = 1'b0;
        chk("abort_reach", (run_beat == 1) && valid_o, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("abort_rd_en", rd_en_o, 0);
        chk("abort_valid", valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_data", data_o, 0);
        chk("abort_addr", rd_addr_o, 0);
        ready_i = 1'b1;
        repeat (3) tick();
        chk("abort_no_done", run_done, 0);
        do_start(2);
        wait_done(100);
        finish_run(2, 7);

        // Full-size readout: last address is 254.
        do_start(255);
        wait_done(1000);
        finish_run(255, 766);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
